mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle MIPS main control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback. It drives all datapath mux selects and enables. It is the producer of the 3-bit ALU operation code consumed by the datapath ALU (AND 000, OR 001, ADD 010, SUB 011). It sits beside the datapath and takes opcode/funct from the instruction register, `zero` from the ALU and `mem_ready` from memory.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 011 SUB
- alu_src_a  out  1  0 PC, 1 A register
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pc_en  out  1  PC load enable
- iord  out  1  0 PC addresses memory, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  IR load enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- illegal  out  1  sticky unsupported-instruction flag
- state  out  4  current state, debug

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, JUMP 10, ADDIEX 11, ADDIWB 12.
- IDLE: all outputs 0. The next state is FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - ir_write and pc_en equal mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R-type -> EXEC
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - anything else -> FETCH, and set illegal
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Wait on mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR: mem_write=1, iord=1. Wait on mem_ready, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op decoded from funct:
  - 100000 -> 010
  - 100010 -> 011
  - 100100 -> 000
  - 100101 -> 001
  - An unsupported funct is decoded in DECODE: the FSM goes to FETCH and sets illegal, and EXEC is never entered.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_en=zero. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, ADD. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- JUMP: pc_source=10, pc_en=1. Next state FETCH.
- Outputs not listed for a state are 0. alu_op defaults to 010.

## Timing
- Reset: rst_n sampled low at an edge -> state=IDLE and illegal=0 after that edge. This applies from any state, including mid-wait; no memory strobe persists after the edge.
- Outputs are combinational from state. The only Mealy terms are ir_write/pc_en from mem_ready in FETCH and pc_en from zero in BRANCH.
- Cycles per instruction, counting FETCH, with mem_ready=1:
  - beq, j: 3
  - R-type, sw, addi: 4
  - lw: 5
  - Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- After reset release: IDLE for one cycle, then FETCH.
- illegal rises the cycle after the DECODE that detects it and holds until reset.

## Configuration
- MC_JUMP_EN defined: j (000010) is supported via the JUMP state.
- Not defined: JUMP is omitted, 000010 is treated as illegal, and pc_source never takes 10.

## Structure
- Shared package mc_pkg holds:
  - state enum
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB
  - opcode and funct constants
  - alu_src_b / pc_source encodings
- Sub-module alu_op_decoder (combinational): funct -> {alu_op, funct_valid}. It is used by EXEC and by the DECODE legality check.

## Test plan
- Hold rst_n=0 for 2 cycles, release -> state 0 then 1; all outputs 0 during IDLE; illegal=0.
- R-type sub (opcode 0, funct 100010), mem_ready=1 -> states 1,2,7,8,1; alu_op=011 in EXEC; reg_write=1 with reg_dst=1 in ALUWB.
- lw with mem_ready low 2 cycles in MEMRD -> MEMRD lasts 3 cycles; mem_read and iord held at 1; then MEMWB with mem_to_reg=1.
- beq with zero=1, then again with zero=0 -> pc_en=1 with pc_source=01, then pc_en=0; both take 3 cycles.
- opcode 111111 -> DECODE to FETCH; illegal=1 thereafter. Then pulse rst_n low during a FETCH wait -> IDLE, illegal=0.
- j with MC_JUMP_EN defined -> JUMP: pc_en=1, pc_source=10. Without the macro -> illegal set, no JUMP state.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct field to ALU operation; funct_valid flags supported functions.
module alu_op_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM (Moore, plus FETCH/BRANCH Mealy enables).
// Define MC_JUMP_EN to support the j instruction through the JUMP state.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_r;
  logic       illegal_r;
  logic [2:0] dec_alu_op;
  logic       funct_valid;

  alu_op_decoder u_dec (
    .funct       (funct),
    .alu_op      (dec_alu_op),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE:   state_r <= S_FETCH;
        S_FETCH:  if (mem_ready) state_r <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_r <= S_MEMADR;
            // Bad funct is caught here so EXEC only ever sees legal R-types.
            OP_RTYPE: begin
              if (funct_valid) begin
                state_r <= S_EXEC;
              end else begin
                state_r   <= S_FETCH;
                illegal_r <= 1'b1;
              end
            end
            OP_BEQ:  state_r <= S_BRANCH;
            OP_ADDI: state_r <= S_ADDIEX;
`ifdef MC_JUMP_EN
            OP_J:    state_r <= S_JUMP;
`endif
            default: begin
              state_r   <= S_FETCH;
              illegal_r <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state_r <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_r <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state_r <= S_FETCH;
        S_EXEC:   state_r <= S_ALUWB;
        S_ADDIEX: state_r <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB: state_r <= S_FETCH;
`ifdef MC_JUMP_EN
        S_JUMP:   state_r <= S_FETCH;
`endif
        default:  state_r <= S_IDLE;
      endcase
    end
  end

  // Control decode from the current state.
  always_comb begin
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_source  = PCSRC_ALU;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state_r)
      S_IDLE: alu_op = ALU_AND;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_ADDIWB: reg_write = 1'b1;
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
      end
`endif
      default: alu_op = ALU_AND;
    endcase
  end

  assign illegal = illegal_r;
  assign state   = state_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm; follows MC_JUMP_EN like the RTL.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic [3:0] st;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .state(st)
  );

  // Control word: {alu_op, src_a, src_b, pc_source, pc_en, iord, mem_read,
  //                mem_write, ir_write, reg_dst, mem_to_reg, reg_write}
  localparam logic [15:0] C_IDLE   = 16'h0000;
  localparam logic [15:0] C_FWAIT  = 16'h4420;
  localparam logic [15:0] C_FRDY   = 16'h44A8;
  localparam logic [15:0] C_DEC    = 16'h4C00;
  localparam logic [15:0] C_MADR   = 16'h5800;
  localparam logic [15:0] C_MRD    = 16'h4060;
  localparam logic [15:0] C_MWB    = 16'h4003;
  localparam logic [15:0] C_MWR    = 16'h4050;
  localparam logic [15:0] C_SUB    = 16'h7000;
  localparam logic [15:0] C_ADD    = 16'h5000;
  localparam logic [15:0] C_AND    = 16'h1000;
  localparam logic [15:0] C_OR     = 16'h3000;
  localparam logic [15:0] C_AWB    = 16'h4005;
  localparam logic [15:0] C_BR_T   = 16'h7180;
  localparam logic [15:0] C_BR_N   = 16'h7100;
  localparam logic [15:0] C_IWB    = 16'h4001;
  localparam logic [15:0] C_JMP    = 16'h4280;

  typedef struct {
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctl;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] s,
                     input logic [15:0] c, input logic il);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.funct = fn; v.zero = z; v.mem_ready = mr;
    v.exp_state = s; v.exp_ctl = c; v.exp_ill = il;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ctl_word();
    return {alu_op, alu_src_a, alu_src_b, pc_source, pc_en, iord, mem_read,
            mem_write, ir_write, reg_dst, mem_to_reg, reg_write};
  endfunction

  initial begin
    bit found;
    // reset, then R-type sub
    add(0, 6'o00, 6'b100010, 0, 1, 4'd0,  C_IDLE,  0);
    add(1, 6'o00, 6'b100010, 0, 1, 4'd0,  C_IDLE,  0);
    add(1, 6'o00, 6'b100010, 0, 1, 4'd1,  C_FRDY,  0);
    add(1, 6'o00, 6'b100010, 0, 1, 4'd2,  C_DEC,   0);
    add(1, 6'o00, 6'b100010, 0, 1, 4'd7,  C_SUB,   0);
    add(1, 6'o00, 6'b100010, 0, 1, 4'd8,  C_AWB,   0);
    // lw with two wait cycles in MEMRD
    add(1, 6'b100011, 6'd0, 0, 1, 4'd1, C_FRDY, 0);
    add(1, 6'b100011, 6'd0, 0, 1, 4'd2, C_DEC,  0);
    add(1, 6'b100011, 6'd0, 0, 1, 4'd3, C_MADR, 0);
    add(1, 6'b100011, 6'd0, 0, 0, 4'd4, C_MRD,  0);
    add(1, 6'b100011, 6'd0, 0, 0, 4'd4, C_MRD,  0);
    add(1, 6'b100011, 6'd0, 0, 1, 4'd4, C_MRD,  0);
    add(1, 6'b100011, 6'd0, 0, 1, 4'd5, C_MWB,  0);
    // beq taken, then not taken
    add(1, 6'b000100, 6'd0, 1, 1, 4'd1, C_FRDY, 0);
    add(1, 6'b000100, 6'd0, 1, 1, 4'd2, C_DEC,  0);
    add(1, 6'b000100, 6'd0, 1, 1, 4'd9, C_BR_T, 0);
    add(1, 6'b000100, 6'd0, 0, 1, 4'd1, C_FRDY, 0);
    add(1, 6'b000100, 6'd0, 0, 1, 4'd2, C_DEC,  0);
    add(1, 6'b000100, 6'd0, 0, 1, 4'd9, C_BR_N, 0);
    // sw with one wait cycle
    add(1, 6'b101011, 6'd0, 0, 1, 4'd1, C_FRDY, 0);
    add(1, 6'b101011, 6'd0, 0, 1, 4'd2, C_DEC,  0);
    add(1, 6'b101011, 6'd0, 0, 1, 4'd3, C_MADR, 0);
    add(1, 6'b101011, 6'd0, 0, 0, 4'd6, C_MWR,  0);
    add(1, 6'b101011, 6'd0, 0, 1, 4'd6, C_MWR,  0);
    // addi after one fetch wait
    add(1, 6'b001000, 6'd0, 0, 0, 4'd1,  C_FWAIT, 0);
    add(1, 6'b001000, 6'd0, 0, 1, 4'd1,  C_FRDY,  0);
    add(1, 6'b001000, 6'd0, 0, 1, 4'd2,  C_DEC,   0);
    add(1, 6'b001000, 6'd0, 0, 1, 4'd11, C_MADR,  0);
    add(1, 6'b001000, 6'd0, 0, 1, 4'd12, C_IWB,   0);
    // remaining R-type functs
    add(1, 6'd0, 6'b100000, 0, 1, 4'd1, C_FRDY, 0);
    add(1, 6'd0, 6'b100000, 0, 1, 4'd2, C_DEC,  0);
    add(1, 6'd0, 6'b100000, 0, 1, 4'd7, C_ADD,  0);
    add(1, 6'd0, 6'b100000, 0, 1, 4'd8, C_AWB,  0);
    add(1, 6'd0, 6'b100100, 0, 1, 4'd1, C_FRDY, 0);
    add(1, 6'd0, 6'b100100, 0, 1, 4'd2, C_DEC,  0);
    add(1, 6'd0, 6'b100100, 0, 1, 4'd7, C_AND,  0);
    add(1, 6'd0, 6'b100100, 0, 1, 4'd8, C_AWB,  0);
    add(1, 6'd0, 6'b100101, 0, 1, 4'd1, C_FRDY, 0);
    add(1, 6'd0, 6'b100101, 0, 1, 4'd2, C_DEC,  0);
    add(1, 6'd0, 6'b100101, 0, 1, 4'd7, C_OR,   0);
    add(1, 6'd0, 6'b100101, 0, 1, 4'd8, C_AWB,  0);
    // unsupported funct: DECODE -> FETCH, illegal set
    add(1, 6'd0, 6'b000000, 0, 1, 4'd1, C_FRDY,  0);
    add(1, 6'd0, 6'b000000, 0, 0, 4'd2, C_DEC,   0);
    add(1, 6'd0, 6'b000000, 0, 0, 4'd1, C_FWAIT, 1);
    // reset during a fetch wait clears illegal and strobes
    add(0, 6'd0, 6'b000000, 0, 0, 4'd1, C_FWAIT, 1);
    add(1, 6'b111111, 6'd0, 0, 1, 4'd0, C_IDLE,  0);
    add(1, 6'b111111, 6'd0, 0, 1, 4'd1, C_FRDY,  0);
    add(1, 6'b111111, 6'd0, 0, 0, 4'd2, C_DEC,   0);
    add(1, 6'b111111, 6'd0, 0, 0, 4'd1, C_FWAIT, 1);
    // jump
    add(1, 6'b000010, 6'd0, 0, 1, 4'd1, C_FRDY, 1);
    add(1, 6'b000010, 6'd0, 0, 0, 4'd2, C_DEC,  1);
`ifdef MC_JUMP_EN
    add(1, 6'b000010, 6'd0, 0, 0, 4'd10, C_JMP,   1);
`else
    add(1, 6'b000010, 6'd0, 0, 0, 4'd1,  C_FWAIT, 1);
`endif
    add(1, 6'b000010, 6'd0, 0, 0, 4'd1, C_FWAIT, 1);

    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; opcode = vecs[i].opcode; funct = vecs[i].funct;
      zero = vecs[i].zero; mem_ready = vecs[i].mem_ready;
      #1;
      check($sformatf("vec%0d state", i), {28'd0, st}, {28'd0, vecs[i].exp_state});
      check($sformatf("vec%0d ctl", i), {16'd0, ctl_word()}, {16'd0, vecs[i].exp_ctl});
      check($sformatf("vec%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].exp_ill});
      @(posedge clk);
      @(negedge clk);
    end

    // Reset in the middle of a MEMRD wait.
    opcode = 6'b100011; mem_ready = 1'b1; rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (st == 4'd4) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_memrd", {31'd0, found}, 32'd1);
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("memrd_hold", {28'd0, st, 1'b0, mem_read, iord, 1'b0}, {28'd4, 4'b0110});
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("memrd_reset", {26'd0, st, mem_read, iord}, {26'd0, 4'd0, 2'b00});
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_fetch", {28'd0, st}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
